// File: rtl/lsu_data_port.sv
// Load/store initiator for the data side of the OTTER memory. One request is in
// flight at a time; every output is a flop, so REQ_* never reaches MEM_* combinationally.
module lsu_data_port #(
  parameter int          TAG_W       = 5,
  parameter bit          ALIGN_CHECK = 1'b1,
  parameter logic [31:0] IO_BASE     = 32'h00010000
) (
  input  logic             LSU_CLK,
  input  logic             LSU_RST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic             REQ_WE,
  input  logic [31:0]      REQ_ADDR,
  input  logic [31:0]      REQ_WDATA,
  input  logic [1:0]       REQ_SIZE,
  input  logic             REQ_SIGN,
  input  logic [TAG_W-1:0] REQ_TAG,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [31:0]      RSP_RDATA,
  output logic [TAG_W-1:0] RSP_TAG,
  output logic             RSP_ERR,
  output logic             RSP_IO,
  output logic             MEM_RDEN2,
  output logic             MEM_WE2,
  output logic [31:0]      MEM_ADDR2,
  output logic [31:0]      MEM_DIN2,
  output logic [1:0]       MEM_SIZE,
  output logic             MEM_SIGN,
  input  logic [31:0]      MEM_DOUT2
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q;
  logic             ready_q;
  logic             rden_q;
  logic             wen_q;
  logic             we_q;
  logic             rspValid_q;
  logic             rspErr_q;
  logic             rspIo_q;
  logic [31:0]      memAddr_q;
  logic [31:0]      memDin_q;
  logic [1:0]       memSize_q;
  logic             memSign_q;
  logic [31:0]      rspRdata_q;
  logic [TAG_W-1:0] rspTag_q;
  logic             reqErr_d;

  // Size 3, unaligned words and halves that would straddle a word are refused.
  always_comb begin
    reqErr_d = 1'b0;
    if (ALIGN_CHECK) begin
      reqErr_d = (REQ_SIZE == 2'd3) ||
                 (REQ_SIZE == 2'd2 && REQ_ADDR[1:0] != 2'b00) ||
                 (REQ_SIZE == 2'd1 && REQ_ADDR[1:0] == 2'b11);
    end
  end

  // REQ_READY is its own flop so it reads 0 while reset is held.
  always_ff @(posedge LSU_CLK or posedge LSU_RST) begin
    if (LSU_RST) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      rden_q     <= 1'b0;
      wen_q      <= 1'b0;
      we_q       <= 1'b0;
      rspValid_q <= 1'b0;
      rspErr_q   <= 1'b0;
      rspIo_q    <= 1'b0;
      memAddr_q  <= '0;
      memDin_q   <= '0;
      memSize_q  <= '0;
      memSign_q  <= 1'b0;
      rspRdata_q <= '0;
      rspTag_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (REQ_VALID && ready_q) begin
            ready_q    <= 1'b0;
            memAddr_q  <= REQ_ADDR;
            memDin_q   <= REQ_WDATA;
            memSize_q  <= REQ_SIZE;
            memSign_q  <= REQ_SIGN;
            we_q       <= REQ_WE;
            rspTag_q   <= REQ_TAG;
            rspRdata_q <= '0;
            rspErr_q   <= reqErr_d;
            rspIo_q    <= (REQ_ADDR >= IO_BASE);
            if (reqErr_d) begin
              state_q    <= RESP;
              rspValid_q <= 1'b1;
            end else begin
              state_q <= ISSUE;
              rden_q  <= ~REQ_WE;
              wen_q   <= REQ_WE;
            end
          end
        end
        ISSUE: begin
          rden_q <= 1'b0;
          wen_q  <= 1'b0;
          if (we_q) begin
            state_q    <= RESP;
            rspValid_q <= 1'b1;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // Address, size and sign are still held, so MEM_DOUT2 is the sized word.
          rspRdata_q <= MEM_DOUT2;
          rspValid_q <= 1'b1;
          state_q    <= RESP;
        end
        RESP: begin
          if (RSP_READY) begin
            rspValid_q <= 1'b0;
            ready_q    <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign REQ_READY = ready_q;
  assign RSP_VALID = rspValid_q;
  assign RSP_RDATA = rspRdata_q;
  assign RSP_TAG   = rspTag_q;
  assign RSP_ERR   = rspErr_q;
  assign RSP_IO    = rspIo_q;
  assign MEM_RDEN2 = rden_q;
  assign MEM_WE2   = wen_q;
  assign MEM_ADDR2 = memAddr_q;
  assign MEM_DIN2  = memDin_q;
  assign MEM_SIZE  = memSize_q;
  assign MEM_SIGN  = memSign_q;

endmodule

// File: tb/tb_lsu_data_port.sv
// Bench for lsu_data_port: a byte-addressed OTTER-style memory with an MMIO window,
// a transaction-level reference model and a per-cycle compare process.
module tb_lsu_data_port;

  localparam int          TAG_W   = 5;
  localparam logic [31:0] IO_BASE = 32'h00010000;

  logic             LSU_CLK = 1'b0;
  logic             LSU_RST;
  logic             REQ_VALID;
  logic             REQ_READY;
  logic             REQ_WE;
  logic [31:0]      REQ_ADDR;
  logic [31:0]      REQ_WDATA;
  logic [1:0]       REQ_SIZE;
  logic             REQ_SIGN;
  logic [TAG_W-1:0] REQ_TAG;
  logic             RSP_VALID;
  logic             RSP_READY;
  logic [31:0]      RSP_RDATA;
  logic [TAG_W-1:0] RSP_TAG;
  logic             RSP_ERR;
  logic             RSP_IO;
  logic             MEM_RDEN2;
  logic             MEM_WE2;
  logic [31:0]      MEM_ADDR2;
  logic [31:0]      MEM_DIN2;
  logic [1:0]       MEM_SIZE;
  logic             MEM_SIGN;
  logic [31:0]      MEM_DOUT2 = 32'h0;

  logic [31:0] ioIn = 32'h5A5A0001;
  logic        ioWr;

  int checks   = 0;
  int failures = 0;

  lsu_data_port #(.TAG_W(TAG_W), .ALIGN_CHECK(1'b1), .IO_BASE(IO_BASE)) dut (
    .LSU_CLK(LSU_CLK), .LSU_RST(LSU_RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_SIZE(REQ_SIZE),
    .REQ_SIGN(REQ_SIGN), .REQ_TAG(REQ_TAG),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
    .RSP_TAG(RSP_TAG), .RSP_ERR(RSP_ERR), .RSP_IO(RSP_IO),
    .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .MEM_ADDR2(MEM_ADDR2),
    .MEM_DIN2(MEM_DIN2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
    .MEM_DOUT2(MEM_DOUT2)
  );

  always #5 LSU_CLK = ~LSU_CLK;

  function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void timeoutFail(string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
  endfunction

  // Sizing and extension rules; REQ_SIGN=1 means unsigned.
  function automatic logic [31:0] extendRaw(logic [31:0] raw, logic [1:0] size, logic sign);
    case (size)
      2'd0:    return sign ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'd1:    return sign ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // Memory seen through the DUT's strobes.
  logic [7:0] envMem[int];
  // Memory as the request stream says it must be.
  logic [7:0] refMem[int];

  function automatic logic [7:0] ioByte(logic [31:0] a);
    return ioIn[8*int'(a[1:0]) +: 8];
  endfunction

  function automatic logic [7:0] envByte(logic [31:0] a);
    if (a >= IO_BASE) return ioByte(a);
    return envMem.exists(int'(a)) ? envMem[int'(a)] : 8'h00;
  endfunction

  function automatic logic [7:0] refByte(logic [31:0] a);
    if (a >= IO_BASE) return ioByte(a);
    return refMem.exists(int'(a)) ? refMem[int'(a)] : 8'h00;
  endfunction

  function automatic logic [31:0] envRead(logic [31:0] a, logic [1:0] size, logic sign);
    logic [31:0] raw;
    int n;
    raw = 32'h0;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) raw = raw | ({24'h0, envByte(a + 32'(i))} << (8 * i));
    return extendRaw(raw, size, sign);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] word);
    for (int i = 0; i < 4; i++) begin
      envMem[int'(a) + i] = word[8*i +: 8];
      refMem[int'(a) + i] = word[8*i +: 8];
    end
  endtask

  // Synchronous-read data port: data appears the cycle after MEM_RDEN2.
  always @(posedge LSU_CLK) begin
    if (MEM_WE2 && MEM_ADDR2 < IO_BASE) begin
      for (int i = 0; i < ((MEM_SIZE == 2'd0) ? 1 : (MEM_SIZE == 2'd1) ? 2 : 4); i++)
        envMem[int'(MEM_ADDR2) + i] = MEM_DIN2[8*i +: 8];
    end
    if (MEM_RDEN2) MEM_DOUT2 <= envRead(MEM_ADDR2, MEM_SIZE, MEM_SIGN);
  end

  assign ioWr = MEM_WE2 && (MEM_ADDR2 >= IO_BASE);

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sign;
    logic [4:0]  tag;
    logic [31:0] rdata;
    logic        err;
    logic        io;
    int          acc;
    int          due;
  } txn_t;

  txn_t pend[$];

  // acc is the compare-cycle index right after the accept edge; due is when RSP_VALID rises.
  function automatic txn_t modelRequest(logic we, logic [31:0] addr, logic [31:0] wdata,
                                        logic [1:0] size, logic sign, logic [4:0] tag, int acc);
    txn_t t;
    logic [31:0] raw;
    int n;
    t.we = we; t.addr = addr; t.wdata = wdata; t.size = size; t.sign = sign; t.tag = tag;
    t.err = (size == 2'd3) || (size == 2'd2 && addr[1:0] != 2'b00) ||
            (size == 2'd1 && addr[1:0] == 2'b11);
    t.io = (addr >= IO_BASE);
    t.rdata = 32'h0;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    if (!t.err) begin
      if (we) begin
        if (!t.io) for (int i = 0; i < n; i++) refMem[int'(addr) + i] = wdata[8*i +: 8];
      end else begin
        raw = 32'h0;
        for (int i = 0; i < n; i++) raw = raw | ({24'h0, refByte(addr + 32'(i))} << (8 * i));
        t.rdata = extendRaw(raw, size, sign);
      end
    end
    t.acc = acc;
    t.due = t.err ? acc : (we ? acc + 1 : acc + 2);
    return t;
  endfunction

  int nc = 0;
  int sinceRst = 0;
  int rdenCount = 0;
  int weCount = 0;
  int ioWrCount = 0;

  always @(negedge LSU_CLK) begin
    txn_t t;
    logic expReady;
    logic expValid;
    nc++;
    if (LSU_RST) begin
      pend.delete();
      sinceRst = 0;
      checkOutput("rstReqReady", REQ_READY, 0);
      checkOutput("rstRspValid", RSP_VALID, 0);
      checkOutput("rstRden", MEM_RDEN2, 0);
      checkOutput("rstWe", MEM_WE2, 0);
      checkOutput("rstAddr", MEM_ADDR2, 0);
      checkOutput("rstRdata", RSP_RDATA, 0);
    end else begin
      sinceRst++;
      if (MEM_RDEN2) rdenCount++;
      if (MEM_WE2) weCount++;
      if (ioWr) ioWrCount++;
      expReady = (pend.size() == 0) && (sinceRst >= 2);
      checkOutput("reqReady", REQ_READY, expReady);
      if (pend.size() != 0) begin
        t = pend[0];
        expValid = (nc >= t.due);
        checkOutput("rspValid", RSP_VALID, expValid);
        checkOutput("memAddr", MEM_ADDR2, t.addr);
        checkOutput("memSize", MEM_SIZE, t.size);
        checkOutput("memSign", MEM_SIGN, t.sign);
        checkOutput("memDin", MEM_DIN2, t.wdata);
        checkOutput("memRden", MEM_RDEN2, !t.err && !t.we && nc == t.acc);
        checkOutput("memWe", MEM_WE2, !t.err && t.we && nc == t.acc);
        if (expValid) begin
          checkOutput("rspRdata", RSP_RDATA, t.rdata);
          checkOutput("rspTag", RSP_TAG, t.tag);
          checkOutput("rspErr", RSP_ERR, t.err);
          checkOutput("rspIo", RSP_IO, t.io);
          if (RSP_READY) void'(pend.pop_front());
        end
      end else begin
        checkOutput("idleRspValid", RSP_VALID, 0);
        checkOutput("idleRden", MEM_RDEN2, 0);
        checkOutput("idleWe", MEM_WE2, 0);
      end
      if (REQ_VALID && expReady)
        pend.push_back(modelRequest(REQ_WE, REQ_ADDR, REQ_WDATA, REQ_SIZE, REQ_SIGN,
                                    REQ_TAG, nc + 1));
    end
  end

  // One request through to a consumed response; lat counts edges after the accept edge.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [1:0] size, input logic sign, input logic [4:0] tag,
                               output logic [31:0] rdata, output logic [4:0] rtag,
                               output logic err, output logic io, output int lat);
    int guard;
    @(posedge LSU_CLK); #1;
    REQ_WE = we; REQ_ADDR = addr; REQ_WDATA = wdata; REQ_SIZE = size;
    REQ_SIGN = sign; REQ_TAG = tag; REQ_VALID = 1'b1; RSP_READY = 1'b0;
    guard = 0;
    while (!REQ_READY && guard < 10) begin @(posedge LSU_CLK); #1; guard++; end
    if (!REQ_READY) timeoutFail("reqAcceptWait");
    @(posedge LSU_CLK); #1;
    REQ_VALID = 1'b0;
    lat = 0;
    while (!RSP_VALID && lat < 10) begin @(posedge LSU_CLK); #1; lat++; end
    if (!RSP_VALID) timeoutFail("rspWait");
    rdata = RSP_RDATA; rtag = RSP_TAG; err = RSP_ERR; io = RSP_IO;
    RSP_READY = 1'b1;
    @(posedge LSU_CLK); #1;
    RSP_READY = 1'b0;
  endtask

  task automatic waitValid(input string name);
    int guard;
    guard = 0;
    while (!RSP_VALID && guard < 10) begin @(posedge LSU_CLK); #1; guard++; end
    if (!RSP_VALID) timeoutFail(name);
  endtask

  initial begin
    logic [31:0] rdata;
    logic [4:0]  rtag;
    logic        err;
    logic        io;
    int          lat;
    int          r0, w0, i0;

    LSU_RST = 1'b1; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0;
    REQ_SIZE = '0; REQ_SIGN = 1'b0; REQ_TAG = '0; RSP_READY = 1'b0;
    repeat (3) @(posedge LSU_CLK);
    #1;
    checkOutput("resetReqReady", REQ_READY, 0);
    checkOutput("resetMemSize", MEM_SIZE, 0);
    checkOutput("resetMemDin", MEM_DIN2, 0);
    checkOutput("resetRspTag", RSP_TAG, 0);
    LSU_RST = 1'b0;

    preload(32'h100, 32'hDEADBEEF);
    r0 = rdenCount;
    applyStimulus(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 5'h0A, rdata, rtag, err, io, lat);
    checkOutput("lwData", rdata, 32'hDEADBEEF);
    checkOutput("lwTag", rtag, 5'h0A);
    checkOutput("lwErr", err, 0);
    checkOutput("lwLat", lat, 2);
    checkOutput("lwRdenPulses", rdenCount - r0, 1);
    checkOutput("lwAddrHeld", MEM_ADDR2, 32'h100);

    preload(32'h100, 32'h80FF7F01);
    applyStimulus(1'b0, 32'h103, 32'h0, 2'd0, 1'b0, 5'h01, rdata, rtag, err, io, lat);
    checkOutput("lbSigned", rdata, 32'hFFFFFF80);
    applyStimulus(1'b0, 32'h103, 32'h0, 2'd0, 1'b1, 5'h02, rdata, rtag, err, io, lat);
    checkOutput("lbuUnsigned", rdata, 32'h00000080);

    preload(32'h200, 32'h11223344);
    w0 = weCount;
    applyStimulus(1'b1, 32'h202, 32'h0000ABCD, 2'd1, 1'b0, 5'h03, rdata, rtag, err, io, lat);
    checkOutput("shWePulses", weCount - w0, 1);
    checkOutput("shMemSize", MEM_SIZE, 1);
    checkOutput("shMemDin", MEM_DIN2, 32'h0000ABCD);
    checkOutput("shLat", lat, 1);
    checkOutput("shRdata", rdata, 0);
    applyStimulus(1'b0, 32'h200, 32'h0, 2'd2, 1'b0, 5'h04, rdata, rtag, err, io, lat);
    checkOutput("lwAfterSh", rdata, 32'hABCD3344);

    r0 = rdenCount; w0 = weCount;
    applyStimulus(1'b0, 32'h101, 32'h0, 2'd2, 1'b0, 5'h05, rdata, rtag, err, io, lat);
    checkOutput("misWordErr", err, 1);
    checkOutput("misWordRdata", rdata, 0);
    checkOutput("misWordLat", lat, 0);
    applyStimulus(1'b0, 32'h103, 32'h0, 2'd1, 1'b0, 5'h06, rdata, rtag, err, io, lat);
    checkOutput("misHalfErr", err, 1);
    checkOutput("misHalfLat", lat, 0);
    checkOutput("misNoStrobes", (rdenCount - r0) + (weCount - w0), 0);

    applyStimulus(1'b0, 32'h11000, 32'h0, 2'd2, 1'b0, 5'h07, rdata, rtag, err, io, lat);
    checkOutput("ioLoadIo", io, 1);
    checkOutput("ioLoadData", rdata, 32'h5A5A0001);
    i0 = ioWrCount;
    applyStimulus(1'b1, 32'h11000, 32'h12345678, 2'd2, 1'b0, 5'h08, rdata, rtag, err, io, lat);
    checkOutput("ioWrPulses", ioWrCount - i0, 1);

    // Backpressure with the next request already waiting on REQ_VALID.
    @(posedge LSU_CLK); #1;
    REQ_WE = 1'b0; REQ_ADDR = 32'h200; REQ_SIZE = 2'd2; REQ_SIGN = 1'b0; REQ_TAG = 5'h09;
    REQ_VALID = 1'b1; RSP_READY = 1'b0;
    while (!REQ_READY) begin @(posedge LSU_CLK); #1; end
    @(posedge LSU_CLK); #1;
    REQ_WE = 1'b1; REQ_ADDR = 32'h204; REQ_WDATA = 32'h55AA55AA; REQ_TAG = 5'h0B;
    waitValid("bpRspWait");
    for (int k = 0; k < 5; k++) begin
      checkOutput("bpReqReady", REQ_READY, 0);
      checkOutput("bpRspValid", RSP_VALID, 1);
      checkOutput("bpRdata", RSP_RDATA, 32'hABCD3344);
      checkOutput("bpTag", RSP_TAG, 5'h09);
      @(posedge LSU_CLK); #1;
    end
    RSP_READY = 1'b1;
    @(posedge LSU_CLK); #1;
    RSP_READY = 1'b0;
    checkOutput("bpBackIdle", REQ_READY, 1);
    checkOutput("bpValidDrop", RSP_VALID, 0);
    @(posedge LSU_CLK); #1;
    REQ_VALID = 1'b0;
    checkOutput("bpNextAccepted", REQ_READY, 0);
    checkOutput("bpNextAddr", MEM_ADDR2, 32'h204);
    waitValid("bpStoreRspWait");
    RSP_READY = 1'b1;
    @(posedge LSU_CLK); #1;
    RSP_READY = 1'b0;

    // Reset while a load sits in WAIT.
    @(posedge LSU_CLK); #1;
    REQ_WE = 1'b0; REQ_ADDR = 32'h100; REQ_SIZE = 2'd2; REQ_TAG = 5'h1F; REQ_VALID = 1'b1;
    while (!REQ_READY) begin @(posedge LSU_CLK); #1; end
    @(posedge LSU_CLK); #1;
    REQ_VALID = 1'b0;
    @(posedge LSU_CLK); #1;
    LSU_RST = 1'b1;
    #1;
    checkOutput("midRstValid", RSP_VALID, 0);
    checkOutput("midRstRdata", RSP_RDATA, 0);
    checkOutput("midRstTag", RSP_TAG, 0);
    checkOutput("midRstAddr", MEM_ADDR2, 0);
    checkOutput("midRstStrobes", {MEM_RDEN2, MEM_WE2}, 0);
    checkOutput("midRstReady", REQ_READY, 0);
    @(posedge LSU_CLK); #1;
    LSU_RST = 1'b0;
    repeat (4) @(posedge LSU_CLK);
    #1;
    checkOutput("midRstNoRsp", RSP_VALID, 0);

    for (int i = 0; i < 600; i++) begin
      @(posedge LSU_CLK); #1;
      REQ_VALID = 1'($urandom_range(0, 1));
      REQ_WE    = 1'($urandom_range(0, 1));
      REQ_ADDR  = ($urandom_range(0, 7) == 0) ? IO_BASE + 32'h1000 + 32'($urandom_range(0, 15))
                                              : 32'h100 + 32'($urandom_range(0, 63));
      REQ_WDATA = $urandom;
      REQ_SIZE  = 2'($urandom_range(0, 3));
      REQ_SIGN  = 1'($urandom_range(0, 1));
      REQ_TAG   = 5'($urandom_range(0, 31));
      RSP_READY = ($urandom_range(0, 3) != 0);
    end
    @(posedge LSU_CLK); #1;
    REQ_VALID = 1'b0;
    RSP_READY = 1'b1;
    repeat (10) @(posedge LSU_CLK);
    #1;
    checkOutput("drainIdle", REQ_READY, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
